// File: rtl/iir_pkg.sv
// Shared defaults and saturation limits for the IIR inverse filter.
package iir_pkg;
  localparam int DATA_W_DEF   = 16;
  localparam int IN_SHIFT_DEF = 2;
  localparam int FB_SHIFT_DEF = 1;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  localparam sample_t SAT_MAX = sample_t'((2 ** (DATA_W_DEF - 1)) - 1);
  localparam sample_t SAT_MIN = sample_t'(-(2 ** (DATA_W_DEF - 1)));
endpackage

// File: rtl/iir_inverse_filter_sat_clamp.sv
// Combinational signed clamp from IN_W down to OUT_W bits, flagging overflow.
module sat_clamp #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             ovf_o
);
  // Value fits iff every bit from the output sign bit upward agrees.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = din_i[IN_W-1:OUT_W-1];
  assign ovf_o    = !((&top_bits) || !(|top_bits));

  always_comb begin
    dout_o = din_i[OUT_W-1:0];
    if (ovf_o)
      dout_o = din_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end
endmodule

// File: rtl/iir_inverse_filter.sv
// Two-stage elastic inverse of y[n] = x[n]>>>IN_SHIFT + y[n-1]>>>FB_SHIFT.
module iir_inverse_filter
  import iir_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IN_SHIFT = IN_SHIFT_DEF,
  parameter int FB_SHIFT = FB_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              sat_flag,
  output logic [7:0]        sat_count
);
  localparam int D1_W   = DATA_W + 1;
  localparam int WIDE_W = D1_W + IN_SHIFT;

  logic                     v1_q, v2_q, sat_flag_q;
  logic [7:0]               sat_count_q;
  logic signed [DATA_W-1:0] y_prev_q;
  logic [DATA_W-1:0]        m_data_q;
  logic signed [D1_W-1:0]   diff_q, diff_d;
  logic signed [WIDE_W-1:0] wide;
  logic [DATA_W-1:0]        clamped;
  logic                     ovf;
  logic                     adv1, adv2, accept;

  assign adv2    = !v2_q || m_ready;
  assign adv1    = !v1_q || adv2;
  assign s_ready = adv1 && !clear;
  assign accept  = s_valid && s_ready;

  // One extra bit keeps the difference exact for full-scale inputs.
  assign diff_d = D1_W'($signed(s_data)) - D1_W'(y_prev_q >>> FB_SHIFT);
  assign wide   = WIDE_W'(diff_q) <<< IN_SHIFT;

  sat_clamp #(.IN_W(WIDE_W), .OUT_W(DATA_W)) u_clamp (
    .din_i  (wide),
    .dout_o (clamped),
    .ovf_o  (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      y_prev_q    <= '0;
      diff_q      <= '0;
      m_data_q    <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else if (clear) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      y_prev_q    <= '0;
      sat_flag_q  <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (accept) y_prev_q <= $signed(s_data);
      if (adv1) begin
        v1_q <= accept;
        if (accept) diff_q <= diff_d;
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          m_data_q <= clamped;
          if (ovf) begin
            sat_flag_q <= 1'b1;
            if (sat_count_q != 8'hFF) sat_count_q <= sat_count_q + 8'd1;
          end
        end
      end
    end
  end

  assign m_valid   = v2_q;
  assign m_data    = m_data_q;
  assign sat_flag  = sat_flag_q;
  assign sat_count = sat_count_q;
endmodule

// File: doc/iir_inverse_filter.md
IIR_INVERSE_FILTER -- requirements
Module: iir_inverse_filter

Interface
REQ-001 Parameter DATA_W, default 16, sample width (signed, two's complement).
REQ-002 Parameter IN_SHIFT, default 2, input attenuation shift of the forward filter being inverted.
REQ-003 Parameter FB_SHIFT, default 1, feedback shift of the forward filter being inverted.
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 clear  input  1  synchronous flush: zero history, drop in-flight samples.
REQ-007 s_valid  input  1  upstream filtered sample valid.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 s_data  input  DATA_W  signed filtered sample y[n].
REQ-010 m_valid  output  1  recovered sample valid.
REQ-011 m_ready  input  1  downstream accepts m_data.
REQ-012 m_data  output  DATA_W  signed recovered sample x[n].
REQ-013 sat_flag  output  1  sticky: any output clamped since reset/clear.
REQ-014 sat_count  output  8  number of clamped outputs, saturating at 255.

Function
REQ-015 Transfer: x[n] = (y[n] - (y[n-1] >>> FB_SHIFT)) <<< IN_SHIFT, with arithmetic right shift (floor).
REQ-016 Accept = s_valid && s_ready; only accepted samples update history y_prev (y_prev <= s_data).
REQ-017 y_prev = 0 after reset or clear; the first sample uses y[-1] = 0.
REQ-018 Stage 1 (on accept): diff = y[n] - (y_prev >>> FB_SHIFT), computed in DATA_W+1 bits, no overflow.
REQ-019 Stage 2: shifted = diff <<< IN_SHIFT in DATA_W+1+IN_SHIFT bits, clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-020 Latency: accept in cycle t -> m_valid with that sample in cycle t+2, given m_ready held high.
REQ-021 Elastic pipeline: adv2 = !v2 || m_ready; adv1 = !v1 || adv2; s_ready = adv1 && !clear.
REQ-022 Throughput 1 sample/cycle while m_ready is high; no sample is dropped or duplicated under backpressure.
REQ-023 While m_valid && !m_ready: m_data and m_valid are held stable.
REQ-024 Clamp event: sat_flag <= 1 and sat_count increments (sticky at 255) once per clamped sample, counted when it enters stage 2.
REQ-025 clear: v1, v2, y_prev, sat_flag, sat_count -> 0 on the next edge; s_ready is low during the clear cycle.
REQ-026 clear and s_valid in the same cycle: clear wins, the input is not accepted, and history is not updated.
REQ-027 A sample held in stage 2 under backpressure is discarded by clear and never presented.

Reset
REQ-028 rst is synchronous, active-high, and has priority over clear and all data.
REQ-029 Reset values: m_valid=0, m_data=0, sat_flag=0, sat_count=0, y_prev=0, internal valids=0.
REQ-030 s_ready = 1 in the first cycle after rst deasserts.
REQ-031 rst asserted mid-stream discards all in-flight samples; no partial output.

Structure
REQ-032 Shared package iir_pkg holds DATA_W, IN_SHIFT, and FB_SHIFT defaults, the sample typedef, and the saturation limit constants.
REQ-033 One sub-module, sat_clamp: combinational clamp of a wide signed value to DATA_W with an overflow flag; instanced in stage 2.

Verification
REQ-034 Constant-input round trip: s_data 100, 150, 175 with m_ready=1 -> m_data 400, 400, 400 at accept+2 cycles.
REQ-035 Positive saturation: after reset, s_data=32767 -> m_data=32767, sat_flag=1, sat_count=1; then s_data=-32768 -> m_data=-32768, sat_count=2.
REQ-036 Backpressure: m_ready=0 for 5 cycles during a stream of 10 samples -> s_ready drops after 2 samples buffered; all 10 outputs delivered in order; m_data stable while stalled.
REQ-037 Clear mid-stream: stage 2 holds a sample with m_ready=0, then clear=1 with s_valid=1 -> sample never emitted, input not accepted; next s_data=100 -> m_data=400.
REQ-038 Reset mid-operation: rst during active stream -> all outputs at reset values next cycle; first post-reset s_data=8 -> m_data=32.
REQ-039 Counter ceiling: 300 clamping samples -> sat_count=255, sat_flag=1, no wrap.
